// File: rtl/csa_mult_8x8.sv
// Two-stage pipelined 8x8 multiplier front end: partial products reduced by CSA trees to a 16-bit sum/carry pair.
// Define CSA_MULT_SIGNED_EN for two's complement operands (Baugh-Wooley); default is unsigned.
module csa_mult_8x8 (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_a,
    input  logic [7:0]  in_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] sum_vec,
    output logic [15:0] carry_vec,
    output logic        busy
);

    function automatic logic [15:0] csa_s(input logic [15:0] a, b, c);
        return a ^ b ^ c;
    endfunction

    function automatic logic [15:0] csa_c(input logic [15:0] a, b, c);
        return ((a & b) | (a & c) | (b & c)) << 1;
    endfunction

    logic        s1_valid_q, s1_valid_d;
    logic        s2_valid_q, s2_valid_d;
    logic [15:0] s1_row_q [4];
    logic [15:0] s1_row_d [4];
    logic [15:0] sum_q, sum_d;
    logic [15:0] carry_q, carry_d;
    logic [15:0] pp [9];
    logic [15:0] l1 [6];
    logic [15:0] l2 [4];
    logic [15:0] m0, m1;
    logic [7:0]  row8;
    logic        s1_adv, s2_adv;

    always_comb begin
        s2_adv = !s2_valid_q || out_ready;
        s1_adv = !s1_valid_q || s2_adv;
    end

    // Stage 1 tree: 8 (or 9 with the Baugh-Wooley constant row) -> 6 -> 4
    always_comb begin
        row8 = '0;
        for (int j = 0; j < 8; j++) begin
            row8 = in_a & {8{in_b[j]}};
`ifdef CSA_MULT_SIGNED_EN
            row8 = row8 ^ ((j == 7) ? 8'h7F : 8'h80);
`endif
            pp[j] = {8'h00, row8} << j;
        end
`ifdef CSA_MULT_SIGNED_EN
        pp[8] = 16'h8100;
`else
        pp[8] = 16'h0000;
`endif
        l1[0] = csa_s(pp[0], pp[1], pp[2]);
        l1[1] = csa_c(pp[0], pp[1], pp[2]);
        l1[2] = csa_s(pp[3], pp[4], pp[5]);
        l1[3] = csa_c(pp[3], pp[4], pp[5]);
`ifdef CSA_MULT_SIGNED_EN
        l1[4] = csa_s(pp[6], pp[7], pp[8]);
        l1[5] = csa_c(pp[6], pp[7], pp[8]);
`else
        l1[4] = pp[6];
        l1[5] = pp[7];
`endif
        l2[0] = csa_s(l1[0], l1[1], l1[2]);
        l2[1] = csa_c(l1[0], l1[1], l1[2]);
        l2[2] = csa_s(l1[3], l1[4], l1[5]);
        l2[3] = csa_c(l1[3], l1[4], l1[5]);
    end

    // Stage 2 tree: 4 -> 3 -> 2
    always_comb begin
        m0 = csa_s(s1_row_q[0], s1_row_q[1], s1_row_q[2]);
        m1 = csa_c(s1_row_q[0], s1_row_q[1], s1_row_q[2]);
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s2_valid_d = s2_valid_q;
        s1_row_d   = s1_row_q;
        sum_d      = sum_q;
        carry_d    = carry_q;
        if (s1_adv) begin
            s1_valid_d = in_valid;
            if (in_valid) s1_row_d = l2;
        end
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                sum_d   = csa_s(m0, m1, s1_row_q[3]);
                carry_d = csa_c(m0, m1, s1_row_q[3]);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            sum_q      <= '0;
            carry_q    <= '0;
            for (int i = 0; i < 4; i++) s1_row_q[i] <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            sum_q      <= sum_d;
            carry_q    <= carry_d;
            for (int i = 0; i < 4; i++) s1_row_q[i] <= s1_row_d[i];
        end
    end

    assign in_ready  = s1_adv;
    assign out_valid = s2_valid_q;
    assign busy      = s1_valid_q || s2_valid_q;
    assign sum_vec   = sum_q;
    assign carry_vec = carry_q;

endmodule

// File: tb/tb_csa_mult_8x8.sv
// Scoreboard bench for csa_mult_8x8: expected products queued on accept, compared on output handshake.
// Build with CSA_MULT_SIGNED_EN to check the signed variant.
module tb_csa_mult_8x8;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum_vec;
    logic [15:0] carry_vec;
    logic        busy;

    csa_mult_8x8 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum_vec   (sum_vec),
        .carry_vec (carry_vec),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [15:0] sb_q [$];
    logic        ov_seen;
    logic        rdy_seen;
    logic [15:0] ps_seen;
    logic        stall_prev = 1'b0;
    logic [15:0] sum_prev;
    logic [15:0] car_prev;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b);
        int p;
`ifdef CSA_MULT_SIGNED_EN
        p = int'($signed(a)) * int'($signed(b));
`else
        p = int'({24'h0, a}) * int'({24'h0, b});
`endif
        return p[15:0];
    endfunction

    task automatic cycle(input logic v, input logic [7:0] a, input logic [7:0] b, input logic ordy);
        logic [15:0] s;
        @(negedge clk);
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        out_ready = ordy;
        #1;
        s        = sum_vec + carry_vec;
        ov_seen  = out_valid;
        rdy_seen = in_ready;
        ps_seen  = s;
        chk("busy", {31'h0, busy}, {31'h0, sb_q.size() != 0});
        if (stall_prev) begin
            chk("hold_v", {31'h0, out_valid}, 32'h1);
            chk("hold_s", {16'h0, sum_vec}, {16'h0, sum_prev});
            chk("hold_c", {16'h0, carry_vec}, {16'h0, car_prev});
        end
        if (out_valid && out_ready) begin
            if (sb_q.size() == 0) chk("spurious", {31'h0, out_valid}, 32'h0);
            else chk("prod", {16'h0, s}, {16'h0, sb_q.pop_front()});
        end
        stall_prev = out_valid && !out_ready;
        sum_prev   = sum_vec;
        car_prev   = carry_vec;
        if (v && in_ready) sb_q.push_back(model(a, b));
    endtask

    task automatic one(input string tag, input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp);
        cycle(1'b1, a, b, 1'b1);
        chk({tag, "_rdy"}, {31'h0, rdy_seen}, 32'h1);
        cycle(1'b0, 8'h00, 8'h00, 1'b1);
        chk({tag, "_lat1"}, {31'h0, ov_seen}, 32'h0);
        cycle(1'b0, 8'h00, 8'h00, 1'b1);
        chk({tag, "_lat2"}, {31'h0, ov_seen}, 32'h1);
        chk(tag, {16'h0, ps_seen}, {16'h0, exp});
    endtask

    initial begin
        int first;
        int last;
        int nov;
        int acc;
        int cyc;
        logic v;
        logic r;

        rst = 1'b1;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        out_ready = 1'b1;
        #12;
        chk("rst_ov", {31'h0, out_valid}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_sum", {16'h0, sum_vec}, 32'h0);
        chk("rst_car", {16'h0, carry_vec}, 32'h0);
        chk("rst_rdy", {31'h0, in_ready}, 32'h1);
        @(negedge clk);
        rst = 1'b0;

`ifdef CSA_MULT_SIGNED_EN
        one("ff_ff", 8'hFF, 8'hFF, 16'h0001);
        one("m128sq", 8'h80, 8'h80, 16'h4000);
        one("m1x1", 8'hFF, 8'h01, 16'hFFFF);
        one("p127xm128", 8'h7F, 8'h80, 16'hC080);
`else
        one("ff_ff", 8'hFF, 8'hFF, 16'hFE01);
        one("ff_01", 8'hFF, 8'h01, 16'h00FF);
        one("80_80", 8'h80, 8'h80, 16'h4000);
`endif

        // back-to-back stream
        first = -1;
        last  = -1;
        nov   = 0;
        for (int i = 0; i < 22; i++) begin
            v = (i < 20);
            cycle(v, 8'($urandom), 8'($urandom), 1'b1);
            if (v) chk("str_rdy", {31'h0, rdy_seen}, 32'h1);
            if (ov_seen) begin
                nov++;
                if (first < 0) first = i;
                last = i;
            end
        end
        chk("str_cnt", nov, 20);
        chk("str_gap", last - first, 19);

        // backpressure
        cycle(1'b1, 8'h11, 8'h22, 1'b0);
        cycle(1'b1, 8'h33, 8'h44, 1'b0);
        cycle(1'b1, 8'h55, 8'h66, 1'b0);
        chk("bp_full", {31'h0, rdy_seen}, 32'h0);
        cycle(1'b1, 8'h55, 8'h66, 1'b0);
        chk("bp_full2", {31'h0, rdy_seen}, 32'h0);
        cycle(1'b1, 8'h55, 8'h66, 1'b1);
        chk("bp_same", {31'h0, rdy_seen}, 32'h1);
        for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 8'h00, 1'b1);
        chk("bp_drain", sb_q.size(), 0);

        // random handshake toggling
        acc = 0;
        cyc = 0;
        while (acc < 10000 && cyc < 60000) begin
            v = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 3) != 0);
            cycle(v, 8'($urandom), 8'($urandom), r);
            if (v && rdy_seen) acc++;
            cyc++;
        end
        chk("rand_acc", acc, 10000);
        cyc = 0;
        while (sb_q.size() != 0 && cyc < 20) begin
            cycle(1'b0, 8'h00, 8'h00, 1'b1);
            cyc++;
        end
        chk("rand_drain", sb_q.size(), 0);

        // reset while full and stalled
        cycle(1'b1, 8'h9A, 8'hBC, 1'b0);
        cycle(1'b1, 8'hDE, 8'hF0, 1'b0);
        cycle(1'b0, 8'h00, 8'h00, 1'b0);
        chk("pre_rst_busy", {31'h0, busy}, 32'h1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_ov", {31'h0, out_valid}, 32'h0);
        chk("arst_busy", {31'h0, busy}, 32'h0);
        chk("arst_sum", {16'h0, sum_vec}, 32'h0);
        chk("arst_car", {16'h0, carry_vec}, 32'h0);
        chk("arst_rdy", {31'h0, in_ready}, 32'h1);
        sb_q.delete();
        stall_prev = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        one("post_rst", 8'h12, 8'h34, model(8'h12, 8'h34));
        chk("post_rst_q", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
        $finish;
    end

endmodule
